// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//   Load/store initiator between the execute stage and a word-addressed data
//   memory. Takes one byte-addressed RISC-V load/store per handshake and turns
//   it into word accesses: SW is a single write, SB/SH are read-modify-write,
//   loads read one word and return the extracted, extended value. Bad
//   requests (out of range, bad funct3, misaligned) get an error response and
//   never reach memory.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_funct3        RISC-V width/sign encoding
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   resp_valid        one-cycle response pulse
//   resp_err          request rejected (with resp_valid)
//   resp_rdata        load result, zero when not a valid load response
//   mem_addr          word index to memory
//   mem_write_en      memory write strobe
//   mem_data_out      write data to memory
//   mem_data_in       read data, combinational from mem_addr
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
   parameter int WORD_AW = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_write_en,
   output logic [31:0] mem_data_out,
   input  logic [31:0] mem_data_in
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   // Byte-address bits above the memory window; any set bit is out of range.
   localparam logic [31:0] HI_MASK = ~((32'd1 << (WORD_AW + 2)) - 32'd1);

   state_t              state_q;
   logic [WORD_AW-1:0]  widx_q;
   logic [1:0]          lane_q;
   logic                we_q;
   logic [2:0]          f3_q;
   logic [31:0]         wdata_q;

   logic                req_ready_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic [31:0]         resp_rdata_q;
   logic                mem_we_q;
   logic [31:0]         mem_dout_q;

   logic                req_err_d;
   logic [31:0]         load_d;
   logic [31:0]         merged_d;

   // ---------------------------------------------------------------------
   // Request check, evaluated on the incoming request at capture time
   // ---------------------------------------------------------------------
   always_comb begin
      logic range_err, f3_err, mis_err;
      range_err = |(req_addr & HI_MASK);
      if (req_we)
         f3_err = (req_funct3 > 3'd2);
      else
         f3_err = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
      mis_err = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
      req_err_d = range_err || f3_err || mis_err;
   end

   // ---------------------------------------------------------------------
   // Load extraction from the word currently on mem_data_in (used in RD)
   // ---------------------------------------------------------------------
   always_comb begin
      logic [7:0]  ld_byte;
      logic [15:0] ld_half;
      ld_byte = mem_data_in[{lane_q, 3'b000} +: 8];
      // Halfword loads are aligned, so only lane bit 1 selects the half.
      ld_half = lane_q[1] ? mem_data_in[31:16] : mem_data_in[15:0];
      case (f3_q)
         3'd0:    load_d = {{24{ld_byte[7]}}, ld_byte};
         3'd1:    load_d = {{16{ld_half[15]}}, ld_half};
         3'd4:    load_d = {24'd0, ld_byte};
         3'd5:    load_d = {16'd0, ld_half};
         default: load_d = mem_data_in;
      endcase
   end

   // ---------------------------------------------------------------------
   // Sub-word store merge into the word read during RD
   // ---------------------------------------------------------------------
   always_comb begin
      logic [31:0] size_mask, lane_mask;
      case (f3_q[1:0])
         2'd0:    size_mask = 32'h0000_00FF;
         2'd1:    size_mask = 32'h0000_FFFF;
         default: size_mask = 32'hFFFF_FFFF;
      endcase
      lane_mask = size_mask << {lane_q, 3'b000};
      merged_d  = (mem_data_in & ~lane_mask) | ((wdata_q << {lane_q, 3'b000}) & lane_mask);
   end

   // ---------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         widx_q       <= '0;
         lane_q       <= '0;
         we_q         <= 1'b0;
         f3_q         <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_we_q     <= 1'b0;
         mem_dout_q   <= '0;
      end else begin
         // Pulse-type outputs default low; only the transition into the
         // state that owns them raises them for exactly one cycle.
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_we_q     <= 1'b0;

         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  widx_q      <= req_addr[WORD_AW+1:2];
                  lane_q      <= req_addr[1:0];
                  we_q        <= req_we;
                  f3_q        <= req_funct3;
                  wdata_q     <= req_wdata;
                  req_ready_q <= 1'b0;
                  if (req_err_d) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                  end else if (req_we && (req_funct3 == 3'd2)) begin
                     // Full-word store needs no read; go straight to write.
                     state_q    <= WR;
                     mem_we_q   <= 1'b1;
                     mem_dout_q <= req_wdata;
                  end else begin
                     state_q <= RD;
                  end
               end
            end

            RD: begin
               // The read word is consumed here; later memory changes are
               // invisible to this request.
               if (!we_q) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= load_d;
               end else begin
                  state_q    <= WR;
                  mem_we_q   <= 1'b1;
                  mem_dout_q <= merged_d;
               end
            end

            WR: begin
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
            end

            RESP: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
            end

            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign resp_valid   = resp_valid_q;
   assign resp_err     = resp_err_q;
   assign resp_rdata   = resp_rdata_q;
   assign mem_addr     = {{(32-WORD_AW){1'b0}}, widx_q};
   assign mem_write_en = mem_we_q;
   assign mem_data_out = mem_dout_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr;
   logic        mem_write_en;
   logic [31:0] mem_data_out;
   logic [31:0] mem_data_in;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.WORD_AW(9)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en),
      .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
   );

   // ---------------- memory attached to the DUT ----------------
   logic [31:0] dmem [512];
   logic        tb_wr = 1'b0;
   logic [8:0]  tb_idx = '0;
   logic [31:0] tb_val = '0;

   assign mem_data_in = (mem_addr < 32'd512) ? dmem[mem_addr[8:0]] : 32'h0;

   always @(posedge clk) begin
      if (mem_write_en && mem_addr < 32'd512) dmem[mem_addr[8:0]] <= mem_data_out;
      else if (tb_wr) dmem[tb_idx] <= tb_val;
   end

   // ---------------- scoring ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   logic [31:0] ref_mem [512];
   bit          busy = 1'b0;
   bit          pristine = 1'b1;
   int          age = 0;
   int          m_lat = 0;
   bit          m_st = 1'b0;
   bit          m_err = 1'b0;
   logic [8:0]  m_idx = '0;
   logic [31:0] m_rdata = '0;
   logic [31:0] m_wword = '0;

   function automatic logic [31:0] load_ref(input logic [31:0] w, input int lane, input logic [2:0] f);
      int v;
      case (f)
         3'd0, 3'd4: begin
            v = int'((w >> (8*lane)) & 32'hFF);
            if (f == 3'd0 && v > 127) v -= 256;
         end
         3'd1, 3'd5: begin
            v = int'((w >> (8*lane)) & 32'hFFFF);
            if (f == 3'd1 && v > 32767) v -= 65536;
         end
         default: v = int'(w);
      endcase
      return 32'(v);
   endfunction

   function automatic logic [31:0] merge_ref(input logic [31:0] w, input int lane, input logic [2:0] f,
                                             input logic [31:0] wd);
      logic [31:0] r;
      int n;
      n = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
      for (int i = 0; i < 4; i++) begin
         if (i >= lane && i < lane + n) r[8*i +: 8] = wd[8*(i-lane) +: 8];
         else                           r[8*i +: 8] = w[8*i +: 8];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (tb_wr) ref_mem[tb_idx] = tb_val;
      // A write is committed at the edge ending its write cycle, even when
      // reset is sampled at that same edge.
      if (busy && m_st && !m_err && age == m_lat - 1) ref_mem[m_idx] = m_wword;
      if (!rst) begin
         busy = 1'b0; age = 0; pristine = 1'b1;
      end else if (busy) begin
         if (age == m_lat) busy = 1'b0;
         else age++;
      end else if (req_valid) begin
         int sz, lane;
         bit bad_f;
         m_st  = req_we;
         bad_f = req_we ? (req_funct3 > 3'd2)
                        : (req_funct3 == 3'd3 || req_funct3 >= 3'd6);
         sz    = 1 << req_funct3[1:0];
         m_err = (req_addr >= 32'd2048) || bad_f || (!bad_f && (req_addr % sz) != 0);
         m_idx = req_addr[10:2];
         lane  = int'(req_addr[1:0]);
         m_lat = m_err ? 1 : (m_st && req_funct3 == 3'd2) ? 2 : m_st ? 3 : 2;
         m_rdata = (!m_err && !m_st) ? load_ref(ref_mem[m_idx], lane, req_funct3) : 32'h0;
         m_wword = merge_ref(ref_mem[m_idx], lane, req_funct3, req_wdata);
         busy = 1'b1; age = 1; pristine = 1'b0;
      end
   end

   // ---------------- per-cycle compare ----------------
   int          resp_cnt = 0;
   int          wr_cnt = 0;
   int          last_lat = 0;
   logic        last_err = 1'b0;
   logic [31:0] last_rdata = '0;
   logic [31:0] last_waddr = '0;
   logic [31:0] last_wdata = '0;

   always @(negedge clk) begin : cmp
      bit erv, ewe;
      erv = busy && (age == m_lat);
      ewe = busy && m_st && !m_err && (age == m_lat - 1);
      chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, erv});
      chk("mem_write_en", {31'd0, mem_write_en}, {31'd0, ewe});
      if (erv) begin
         chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
         chk("resp_rdata", resp_rdata, m_rdata);
      end else begin
         chk("resp_rdata_idle", resp_rdata, 32'h0);
      end
      if (ewe) begin
         chk("mem_addr", mem_addr, {23'd0, m_idx});
         chk("mem_data_out", mem_data_out, m_wword);
      end
      if (pristine) begin
         chk("mem_addr_rst", mem_addr, 32'h0);
         chk("mem_data_out_rst", mem_data_out, 32'h0);
      end
      if (resp_valid) begin
         resp_cnt++; last_err = resp_err; last_rdata = resp_rdata; last_lat = age;
      end
      if (mem_write_en) begin
         wr_cnt++; last_waddr = mem_addr; last_wdata = mem_data_out;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_word(input int idx, input logic [31:0] v);
      @(negedge clk);
      tb_wr = 1'b1; tb_idx = 9'(idx); tb_val = v;
      @(negedge clk);
      tb_wr = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
      if (busy) chk({nm, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic issue(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      wait_idle("issue");
   endtask

   // directed check of one finished request against literal expectations
   task automatic expect_resp(input string nm, input int r0, input int w0, input logic err,
                              input logic [31:0] rd, input int lat, input int nwr);
      chk({nm, "_nresp"}, 32'(resp_cnt - r0), 32'd1);
      chk({nm, "_err"}, {31'd0, last_err}, {31'd0, err});
      chk({nm, "_rdata"}, last_rdata, rd);
      chk({nm, "_lat"}, 32'(last_lat), 32'(lat));
      chk({nm, "_nwr"}, 32'(wr_cnt - w0), 32'(nwr));
   endtask

   initial begin
      int r0, w0;
      rst = 1'b0;
      for (int i = 0; i < 512; i++) set_word(i, $urandom);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);

      // LW
      set_word(4, 32'hDEADBEEF);
      r0 = resp_cnt; w0 = wr_cnt;
      issue(1'b0, 3'd2, 32'h10, 32'h0);
      expect_resp("LW", r0, w0, 1'b0, 32'hDEADBEEF, 2, 0);

      // sub-word loads
      set_word(4, 32'h80FF7F01);
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b0, 3'd0, 32'h13, 32'h0);
      expect_resp("LB", r0, w0, 1'b0, 32'hFFFFFF80, 2, 0);
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b0, 3'd4, 32'h13, 32'h0);
      expect_resp("LBU", r0, w0, 1'b0, 32'h00000080, 2, 0);
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b0, 3'd1, 32'h12, 32'h0);
      expect_resp("LH", r0, w0, 1'b0, 32'hFFFF80FF, 2, 0);
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b0, 3'd5, 32'h10, 32'h0);
      expect_resp("LHU", r0, w0, 1'b0, 32'h00007F01, 2, 0);

      // SB read-modify-write
      set_word(8, 32'h11223344);
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b1, 3'd0, 32'h21, 32'h000000AA);
      expect_resp("SB", r0, w0, 1'b0, 32'h0, 3, 1);
      chk("SB_waddr", last_waddr, 32'd8);
      chk("SB_wdata", last_wdata, 32'h1122AA44);

      // SW then read back
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b1, 3'd2, 32'h24, 32'hCAFEF00D);
      expect_resp("SW", r0, w0, 1'b0, 32'h0, 2, 1);
      chk("SW_waddr", last_waddr, 32'd9);
      chk("SW_wdata", last_wdata, 32'hCAFEF00D);
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b0, 3'd2, 32'h24, 32'h0);
      expect_resp("SW_LW", r0, w0, 1'b0, 32'hCAFEF00D, 2, 0);

      // errors
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b0, 3'd1, 32'h01, 32'h0);
      expect_resp("E_LH", r0, w0, 1'b1, 32'h0, 1, 0);
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b1, 3'd2, 32'h06, 32'h55);
      expect_resp("E_SW", r0, w0, 1'b1, 32'h0, 1, 0);
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b0, 3'd2, 32'h800, 32'h0);
      expect_resp("E_RANGE", r0, w0, 1'b1, 32'h0, 1, 0);
      r0 = resp_cnt; w0 = wr_cnt; issue(1'b0, 3'd3, 32'h0, 32'h0);
      expect_resp("E_F3", r0, w0, 1'b1, 32'h0, 1, 0);

      // reset during RD of an SH
      r0 = resp_cnt; w0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h32; req_wdata = 32'hBEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("RST_ready", {31'd0, req_ready}, 32'd1);
      chk("RST_rv", {31'd0, resp_valid}, 32'd0);
      chk("RST_we", {31'd0, mem_write_en}, 32'd0);
      chk("RST_addr", mem_addr, 32'd0);
      repeat (4) @(negedge clk);
      chk("RST_nresp", 32'(resp_cnt - r0), 32'd0);
      chk("RST_nwr", 32'(wr_cnt - w0), 32'd0);

      // randomized traffic, including ignored inputs while busy and resets
      repeat (4000) begin
         @(negedge clk);
         rst = ($urandom_range(0, 99) != 0);
         req_valid = ($urandom_range(0, 9) < 7);
         req_we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) req_funct3 = 3'($urandom_range(0, 7));
         else if (req_we) req_funct3 = 3'($urandom_range(0, 2));
         else case ($urandom_range(0, 4))
            0: req_funct3 = 3'd0;
            1: req_funct3 = 3'd1;
            2: req_funct3 = 3'd2;
            3: req_funct3 = 3'd4;
            default: req_funct3 = 3'd5;
         endcase
         req_addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
         req_wdata = $urandom;
      end
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b0;
      wait_idle("final");
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
